display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Drives the 4-digit multiplexed seven-segment display's anode lines by time-slicing a single segment bus across the four digits. It sits directly upstream of `seven_seg_decoder` and supplies its 4-bit one-cold `anode` select. The decoder uses that select to pick A, B, A+B or A−B and drive `segs`. The block also gates the anodes with a per-digit mask and a global enable, and can optionally insert anti-ghosting dead time between digits.

## Interface
- `CLK_HZ`, default 100_000_000: input clock frequency.
- `SLOT_HZ`, default 1000: digit-slot rate. `DIV = CLK_HZ/SLOT_HZ` clock cycles per slot; `DIV ≥ 2` is required (elaboration error otherwise).
- `BLANK_CYCLES`, default 1000: dead-time length in cycles (≥ 1). Used only when `SCAN_BLANK_EN` is defined.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst_n`, input, 1: reset. One clock; reset is synchronous and active-low.
- `en`, input, 1: 1 = scan; 0 = display off.
- `digit_mask`, input, 4: bit i = 1 shows digit i. A masked digit still uses its slot, but its anode stays high.
- `anode`, output, 4: one-cold, active-low anode select. Bit i corresponds to digit i (bit 0 = A digit, bit 3 = A−B digit).
- `digit_idx`, output, 2: index of the current slot.
- `slot_tick`, output, 1: one-cycle pulse in the first cycle of each SHOW slot.

## Operation
- States: IDLE, SHOW and BLANK. BLANK exists only when `SCAN_BLANK_EN` is defined.
- Reset values (`rst_n` = 0 at a clock edge):
  - state = IDLE, counter = 0, `digit_idx` = 0.
  - `mask_q` = 4'b0000, `anode` = 4'b1111, `slot_tick` = 0.
- `mask_q` is a register loaded from `digit_mask` every cycle.
- `anode` is decoded combinationally from the registered state, `digit_idx` and `mask_q`:
  - In SHOW, `anode = ~(4'b0001 << digit_idx) | ~mask_q`.
  - In every other state, `anode = 4'b1111`.
- IDLE:
  - Counter held at 0, `digit_idx` forced to 0.
  - When `en` = 1, go to SHOW. `slot_tick` is 1 in the first SHOW cycle.
- SHOW:
  - The counter counts 0..DIV−1.
  - At count DIV−1 with the macro off: `digit_idx` increments modulo 4 (3 → 0), the counter returns to 0, state stays SHOW, and `slot_tick` pulses.
  - At count DIV−1 with the macro on: go to BLANK with the counter cleared. `digit_idx` is unchanged.
- BLANK:
  - Counts 0..BLANK_CYCLES−1.
  - At the last count: `digit_idx` increments modulo 4, go to SHOW, and `slot_tick` pulses.
- `en` = 0 seen in any state: next cycle is IDLE, with counter = 0 and `digit_idx` = 0. An interrupted slot is abandoned, not resumed.
- Simultaneous events:
  - Reset beats `en`.
  - `en` falling on the terminal count goes to IDLE; the index does not advance.
- Counter width is `$clog2(max(DIV, BLANK_CYCLES))`. Comparisons are unsigned and there is no overflow path.

## Timing
- From `rst_n` releasing with `en` = 1: IDLE for one cycle, then SHOW from the second edge.
- From `en` 0→1 sampled at edge k: SHOW and `slot_tick` = 1 after edge k, so `anode` is active one cycle after `en`.
- From `en` 1→0 sampled at edge k: `anode` = 4'b1111 after edge k.
- `digit_mask` reaches `anode` one cycle later (through `mask_q`).
- Slot period:
  - Macro off: DIV cycles.
  - Macro on: DIV + BLANK_CYCLES cycles.
- Full frame period is 4 × slot period.
- `anode` and `digit_idx` change on the same edge. The downstream decoder is combinational and needs no extra alignment.

## Configuration
- `SCAN_BLANK_EN` defined:
  - BLANK state compiled in.
  - All anodes are high for BLANK_CYCLES between consecutive slots, which suppresses ghosting from segment-bus settling.
- Not defined:
  - BLANK state, its counter compare and the `BLANK_CYCLES` check are removed.
  - Slots are back-to-back.
  - Behaviour otherwise identical.

## Structure
- Package `display_scan_pkg` holds:
  - the state enum (`SCAN_IDLE`, `SCAN_SHOW`, `SCAN_BLANK`),
  - the digit-index type (2-bit),
  - the localparams `ANODE_OFF = 4'b1111` and `NUM_DIGITS = 4`.
  - The same package is shared with `seven_seg_decoder` updates.
- One natural sub-module, `scan_prescaler`: a parameterised modulo counter with `clr` and `load_max` inputs and a `terminal` output. It is instantiated once and reloaded with DIV or BLANK_CYCLES per state.

## Test plan
Parameters for all tests unless noted: CLK_HZ = 40, SLOT_HZ = 10 (DIV = 4), BLANK_CYCLES = 2.
- **Reset:** hold `rst_n` = 0 for 3 cycles with `en` = 1 → `anode` = 1111, `digit_idx` = 0, `slot_tick` = 0 throughout.
- **Scan sequence:** macro off, `en` = 1, mask = 1111 → `anode` sequence 1110, 1101, 1011, 0111, each held 4 cycles, then wraps to 1110. `slot_tick` pulses every 4 cycles.
- **Masking:** mask = 0101 → `anode` sequence 1110, 1111, 1011, 1111. `digit_idx` still steps 0–3.
- **Mid-slot disable:** `en` dropped at cycle 2 of digit 2 → `anode` = 1111 next cycle. Re-raising `en` restarts at digit 0 with `slot_tick`.
- **Blanking:** macro on → each 4-cycle active slot is followed by 2 cycles of `anode` = 1111. Frame = 24 cycles.
- **Terminal-count collision:** `en` falling on count 3 of digit 1 → IDLE, `digit_idx` = 0, no `slot_tick`.

Source files
------------

// File: rtl/display_scan_pkg.sv
// Shared types and constants for the display scan path and the seven-segment decoder.
package display_scan_pkg;

   typedef enum logic [1:0] {
      SCAN_IDLE  = 2'd0,
      SCAN_SHOW  = 2'd1,
      SCAN_BLANK = 2'd2
   } scan_state_t;

   typedef logic [1:0] digit_idx_t;

   localparam logic [3:0] ANODE_OFF  = 4'b1111;
   localparam int         NUM_DIGITS = 4;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/display_scan_controller_prescaler.sv
// Modulo counter behind the scan slot timing; wraps to zero after load_max.
module scan_prescaler #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [CNT_W-1:0] load_max,
   output logic             terminal
);

   logic [CNT_W-1:0] count_q;

   assign terminal = (count_q == load_max);

   // Count up, returning to zero on the terminal count or on an explicit clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr || terminal) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/display_scan_controller.sv
// Time-sliced anode scan for a 4-digit multiplexed seven-segment display.
// Build option: define SCAN_BLANK_EN to insert BLANK_CYCLES of all-off dead
// time between digit slots (anti-ghosting); without it slots are back-to-back.
//
// state      | meaning
// SCAN_IDLE  | display off, counter and digit index held at zero
// SCAN_SHOW  | current digit's anode driven (unless masked) for DIV cycles
// SCAN_BLANK | all anodes off for BLANK_CYCLES before the next digit
module display_scan_controller
   import display_scan_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int SLOT_HZ      = 1000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] digit_mask,
   output logic [3:0] anode,
   output logic [1:0] digit_idx,
   output logic       slot_tick
);

   localparam int DIV     = CLK_HZ / SLOT_HZ;
   localparam int CNT_MAX = max_int(DIV, BLANK_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

   generate
      if (DIV < 2) begin : g_div_chk
         $error("display_scan_controller: CLK_HZ/SLOT_HZ must be at least 2");
      end
   endgenerate

`ifdef SCAN_BLANK_EN
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   generate
      if (BLANK_CYCLES < 1) begin : g_blank_chk
         $error("display_scan_controller: BLANK_CYCLES must be at least 1");
      end
   endgenerate
`endif

   scan_state_t      state_q;
   scan_state_t      state_d;
   digit_idx_t       idx_q;
   digit_idx_t       idx_d;
   logic             tick_q;
   logic             tick_d;
   logic [3:0]       mask_q;
   logic             terminal;
   logic             cnt_clr;
   logic [CNT_W-1:0] cnt_max;

   // Counter restarts whenever the scan is parked or about to be parked, so an
   // interrupted slot is never resumed.
   assign cnt_clr = (state_q == SCAN_IDLE) || !en;

`ifdef SCAN_BLANK_EN
   assign cnt_max = (state_q == SCAN_BLANK) ? BLANK_LAST : DIV_LAST;
`else
   assign cnt_max = DIV_LAST;
`endif

   scan_prescaler #(
      .CNT_W (CNT_W)
   ) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (cnt_clr),
      .load_max (cnt_max),
      .terminal (terminal)
   );

   // State, digit index, slot pulse and registered digit mask.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= SCAN_IDLE;
         idx_q   <= '0;
         tick_q  <= 1'b0;
         mask_q  <= 4'b0000;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tick_q  <= tick_d;
         mask_q  <= digit_mask;
      end
   end

   // Next-state logic; a low enable always wins, even on a terminal count.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tick_d  = 1'b0;
      if (!en) begin
         state_d = SCAN_IDLE;
         idx_d   = '0;
      end else begin
         case (state_q)
            SCAN_IDLE: begin
               state_d = SCAN_SHOW;
               idx_d   = '0;
               tick_d  = 1'b1;
            end
            SCAN_SHOW: begin
               if (terminal) begin
`ifdef SCAN_BLANK_EN
                  state_d = SCAN_BLANK;
`else
                  idx_d   = idx_q + 2'd1;
                  tick_d  = 1'b1;
`endif
               end
            end
`ifdef SCAN_BLANK_EN
            SCAN_BLANK: begin
               if (terminal) begin
                  state_d = SCAN_SHOW;
                  idx_d   = idx_q + 2'd1;
                  tick_d  = 1'b1;
               end
            end
`endif
            default: begin
               state_d = SCAN_IDLE;
               idx_d   = '0;
            end
         endcase
      end
   end

   // One-cold anode decode; masked digits keep their slot but stay dark.
   always_comb begin
      anode = ANODE_OFF;
      if (state_q == SCAN_SHOW) begin
         anode = ~(4'b0001 << idx_q) | ~mask_q;
      end
   end

   assign digit_idx = idx_q;
   assign slot_tick = tick_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller at DIV = 4, BLANK_CYCLES = 2.
// Slot period follows the SCAN_BLANK_EN build option.
module tb_display_scan_controller;

   localparam int CLK_HZ  = 40;
   localparam int SLOT_HZ = 10;
   localparam int BLANK   = 2;
`ifdef SCAN_BLANK_EN
   localparam int SP = 6;
`else
   localparam int SP = 4;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [3:0] digit_mask = 4'b0000;
   logic [3:0] anode;
   logic [1:0] digit_idx;
   logic       slot_tick;

   int checks = 0;
   int failures = 0;

   logic [3:0] show_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   display_scan_controller #(
      .CLK_HZ       (CLK_HZ),
      .SLOT_HZ      (SLOT_HZ),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .digit_mask (digit_mask),
      .anode      (anode),
      .digit_idx  (digit_idx),
      .slot_tick  (slot_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] a, input logic [1:0] d, input logic t);
      chk({tag, ".anode"}, {4'b0, anode}, {4'b0, a});
      chk({tag, ".idx"}, {6'b0, digit_idx}, {6'b0, d});
      chk({tag, ".tick"}, {7'b0, slot_tick}, {7'b0, t});
   endtask

   // Expected outputs for cycle i of a scan started from IDLE.
   function automatic logic [3:0] exp_anode(input int i, input logic [3:0] m);
      int p = i % SP;
      int d = (i / SP) % 4;
      return (p < 4) ? (show_tab[d] | ~m) : 4'b1111;
   endfunction

   task automatic start_scan(input logic [3:0] m);
      en = 1'b0;
      digit_mask = m;
      step();
      chk_out("park", 4'b1111, 2'd0, 1'b0);
      en = 1'b1;
   endtask

   task automatic scan_cycles(input string tag, input int n, input logic [3:0] m);
      for (int i = 0; i < n; i++) begin
         step();
         chk_out($sformatf("%s[%0d]", tag, i), exp_anode(i, m),
                 2'((i / SP) % 4), ((i % SP) == 0));
      end
   endtask

   initial begin
      // Reset held with enable high.
      rst_n = 1'b0;
      en = 1'b1;
      digit_mask = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("reset", 4'b1111, 2'd0, 1'b0);
      end
      rst_n = 1'b1;
      scan_cycles("scan", 4 * SP + 4, 4'b1111);

      // Reset mid-scan, then restart.
      rst_n = 1'b0;
      step();
      chk_out("rst_mid", 4'b1111, 2'd0, 1'b0);
      rst_n = 1'b1;
      step();
      chk_out("rst_rel", 4'b1110, 2'd0, 1'b1);

      // Digit masking.
      start_scan(4'b0101);
      scan_cycles("mask", 4 * SP, 4'b0101);

      // Mask reaches anode one cycle later.
      start_scan(4'b1111);
      scan_cycles("mlat", 1, 4'b1111);
      digit_mask = 4'b0000;
      #1;
      chk("mlat.same", {4'b0, anode}, 8'b0000_1110);
      step();
      chk_out("mlat.next", 4'b1111, 2'd0, 1'b0);

      // Enable dropped at count 2 of digit 2.
      start_scan(4'b1111);
      scan_cycles("dis", 2 * SP + 3, 4'b1111);
      en = 1'b0;
      step();
      chk_out("dis.off", 4'b1111, 2'd0, 1'b0);
      step();
      chk_out("dis.hold", 4'b1111, 2'd0, 1'b0);
      en = 1'b1;
      step();
      chk_out("dis.restart", 4'b1110, 2'd0, 1'b1);
      step();
      chk_out("dis.restart1", 4'b1110, 2'd0, 1'b0);

      // Enable falling on the terminal count of digit 1.
      start_scan(4'b1111);
      scan_cycles("tc", SP + 4, 4'b1111);
      en = 1'b0;
      step();
      chk_out("tc.off", 4'b1111, 2'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
